// File: rtl/ahb_led_driver.sv
// AHB-Lite slave driving eight LEDs: DATA sets the pattern, BLINK selects which
// lit bits are blanked during the odd half of a programmable blink period.
module ahb_led_driver #(
    parameter int unsigned CNT_W     = 24,
    parameter logic [7:0]  RESET_LED = 8'h00
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic        HREADY,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic [7:0]  LED
);

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_BLINK  = 2'd1;
    localparam logic [1:0] REG_PERIOD = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             hsel_q;
    logic             trans_q;
    logic             write_q;
    logic [3:0]       addr_q;
    logic [2:0]       size_q;

    logic [7:0]       data_q,   data_d;
    logic [7:0]       blink_q,  blink_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             phase_q,  phase_d;
    logic [7:0]       led_q,    led_d;

    logic             dphaseValid;
    logic             wrEn;
    logic             rdEn;
    logic             wrData;
    logic             wrBlink;
    logic             wrPeriod;
    logic [3:0]       laneMask;
    logic [31:0]      byteMask;
    logic             unusedBits;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hsel_q  <= 1'b0;
            trans_q <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= 4'h0;
            size_q  <= 3'h0;
        end else if (HREADY) begin
            hsel_q  <= HSEL;
            trans_q <= HTRANS[1];
            write_q <= HWRITE;
            addr_q  <= HADDR[3:0];
            size_q  <= HSIZE;
        end
    end

    assign dphaseValid = hsel_q & trans_q;
    assign wrEn        = dphaseValid & write_q & HREADY;
    assign rdEn        = dphaseValid & ~write_q;
    assign wrData      = wrEn && (addr_q[3:2] == REG_DATA);
    assign wrBlink     = wrEn && (addr_q[3:2] == REG_BLINK);
    assign wrPeriod    = wrEn && (addr_q[3:2] == REG_PERIOD);

    // Sizes above word behave as full-word writes.
    always_comb begin
        laneMask = 4'b1111;
        case (size_q)
            3'd0:    laneMask = 4'b0001 << addr_q[1:0];
            3'd1:    laneMask = addr_q[1] ? 4'b1100 : 4'b0011;
            default: laneMask = 4'b1111;
        endcase
    end

    assign byteMask = {{8{laneMask[3]}}, {8{laneMask[2]}}, {8{laneMask[1]}}, {8{laneMask[0]}}};

    assign data_d   = (wrData  && laneMask[0]) ? HWDATA[7:0] : data_q;
    assign blink_d  = (wrBlink && laneMask[0]) ? HWDATA[7:0] : blink_q;
    assign period_d = wrPeriod
                    ? ((period_q & ~byteMask[CNT_W-1:0]) | (HWDATA[CNT_W-1:0] & byteMask[CNT_W-1:0]))
                    : period_q;

    // A PERIOD write restarts the blink cycle and wins over a coincident wrap.
    always_comb begin
        count_d = count_q;
        phase_d = phase_q;
        if (wrPeriod || (period_q == '0)) begin
            count_d = '0;
            phase_d = 1'b0;
        end else if (count_q == period_q - CNT_ONE) begin
            count_d = '0;
            phase_d = ~phase_q;
        end else begin
            count_d = count_q + CNT_ONE;
        end
    end

    assign led_d = data_q & ~(blink_q & {8{phase_q}});

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            data_q   <= RESET_LED;
            blink_q  <= 8'h00;
            period_q <= '0;
            count_q  <= '0;
            phase_q  <= 1'b0;
            led_q    <= RESET_LED;
        end else begin
            data_q   <= data_d;
            blink_q  <= blink_d;
            period_q <= period_d;
            count_q  <= count_d;
            phase_q  <= phase_d;
            led_q    <= led_d;
        end
    end

    always_comb begin
        HRDATA = 32'h0;
        if (rdEn) begin
            case (addr_q[3:2])
                REG_DATA:   HRDATA[7:0]       = data_q;
                REG_BLINK:  HRDATA[7:0]       = blink_q;
                REG_PERIOD: HRDATA[CNT_W-1:0] = period_q;
                REG_STATUS: begin
                    HRDATA[CNT_W:1] = count_q;
                    HRDATA[0]       = phase_q;
                end
                default:    HRDATA = 32'h0;
            endcase
        end
    end

    assign HREADYOUT = 1'b1;
    assign LED       = led_q;

    assign unusedBits = ^{HADDR[31:4], HTRANS[0], HWDATA, byteMask};

endmodule

// File: tb/tb_ahb_led_driver.sv
// Self-checking bench for ahb_led_driver: directed vectors, hand sequences for the
// blink/reset corner cases, then random bus traffic against a transaction-level model.
module tb_ahb_led_driver;

    localparam int unsigned CNT_W     = 24;
    localparam logic [7:0]  RESET_LED = 8'h81;
    localparam logic [31:0] PER_MASK  = 32'((64'd1 << CNT_W) - 64'd1);

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic        HREADY;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic [7:0]  LED;

    int errorCount = 0;
    int checkCount = 0;

    ahb_led_driver #(.CNT_W(CNT_W), .RESET_LED(RESET_LED)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADY),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HWDATA(HWDATA), .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .LED(LED)
    );

    always #5 HCLK = ~HCLK;

    // Model: registers as plain values; blink state derived from cycles since restart.
    logic [7:0]  mData, mBlink, mLed;
    logic [31:0] mPeriod;
    int unsigned mSince;
    logic        mVal, mWr;
    logic [3:0]  mAddr;
    logic [2:0]  mSize;

    function automatic logic mPhase();
        if (mPeriod == 0) return 1'b0;
        return ((mSince / mPeriod) % 2) == 1;
    endfunction

    function automatic logic [31:0] mCount();
        if (mPeriod == 0) return 32'h0;
        return mSince % mPeriod;
    endfunction

    function automatic logic [31:0] expRdata();
        if (!(mVal && !mWr)) return 32'h0;
        case (mAddr[3:2])
            2'd0:    return {24'h0, mData};
            2'd1:    return {24'h0, mBlink};
            2'd2:    return mPeriod;
            default: return (mCount() << 1) | {31'h0, mPhase()};
        endcase
    endfunction

    function automatic logic [31:0] laneBits(input logic [3:0] a, input logic [2:0] s);
        int first;
        int n;
        logic [31:0] m;
        m = 32'h0;
        if (s == 3'd0) begin
            first = int'(a[1:0]); n = 1;
        end else if (s == 3'd1) begin
            first = a[1] ? 2 : 0; n = 2;
        end else begin
            first = 0; n = 4;
        end
        for (int l = first; l < first + n; l++) m |= 32'hFF << (8 * l);
        return m;
    endfunction

    task automatic modelReset();
        mData = RESET_LED; mBlink = 8'h00; mLed = RESET_LED; mPeriod = 32'h0; mSince = 0;
        mVal = 1'b0; mWr = 1'b0; mAddr = 4'h0; mSize = 3'h0;
    endtask

    // Advance one clock: compute next model state from pre-edge values, then step.
    task automatic tick();
        logic [7:0]  nLed, nData, nBlink;
        logic [31:0] nPeriod, m;
        int unsigned nSince;
        logic        perWr, nVal, nWr;
        logic [3:0]  nAddr;
        logic [2:0]  nSize;
        nLed = mData & ~(mBlink & {8{mPhase()}});
        nData = mData; nBlink = mBlink; nPeriod = mPeriod; perWr = 1'b0;
        if (mVal && mWr && HREADY) begin
            m = laneBits(mAddr, mSize);
            case (mAddr[3:2])
                2'd0: nData  = 8'((({24'h0, mData}) & ~m) | (HWDATA & m));
                2'd1: nBlink = 8'((({24'h0, mBlink}) & ~m) | (HWDATA & m));
                2'd2: begin
                    nPeriod = ((mPeriod & ~m) | (HWDATA & m)) & PER_MASK;
                    perWr = 1'b1;
                end
                default: ;
            endcase
        end
        nSince = perWr ? 0 : mSince + 1;
        nVal = mVal; nWr = mWr; nAddr = mAddr; nSize = mSize;
        if (HREADY) begin
            nVal = HSEL && HTRANS[1]; nWr = HWRITE; nAddr = HADDR[3:0]; nSize = HSIZE;
        end
        @(posedge HCLK);
        #1;
        mLed = nLed; mData = nData; mBlink = nBlink; mPeriod = nPeriod; mSince = nSince;
        mVal = nVal; mWr = nWr; mAddr = nAddr; mSize = nSize;
    endtask

    task automatic applyStimulus(input logic sel, input logic [1:0] trans, input logic wr,
                                 input logic [3:0] addr, input logic [2:0] size,
                                 input logic [31:0] wdata, input logic ready);
        HSEL = sel; HTRANS = trans; HWRITE = wr; HADDR = {28'h0, addr};
        HSIZE = size; HWDATA = wdata; HREADY = ready;
    endtask

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name);
        checkVal({name, " LED"}, {24'h0, LED}, {24'h0, mLed});
        checkVal({name, " HRDATA"}, HRDATA, expRdata());
        checkVal({name, " HREADYOUT"}, {31'h0, HREADYOUT}, 32'h1);
    endtask

    task automatic busWrite(input logic [3:0] addr, input logic [2:0] size, input logic [31:0] wdata);
        applyStimulus(1'b1, 2'b10, 1'b1, addr, size, 32'h0, 1'b1);
        tick();
        applyStimulus(1'b0, 2'b00, 1'b0, 4'h0, 3'd2, wdata, 1'b1);
        #1 checkOutput("write dphase");
        tick();
    endtask

    task automatic busRead(input logic [3:0] addr, output logic [31:0] rdata);
        applyStimulus(1'b1, 2'b10, 1'b0, addr, 3'd2, 32'h0, 1'b1);
        tick();
        applyStimulus(1'b0, 2'b00, 1'b0, 4'h0, 3'd2, 32'h0, 1'b1);
        #1 rdata = HRDATA;
        checkOutput("read dphase");
        tick();
    endtask

    task automatic writeRead(input logic [3:0] waddr, input logic [2:0] wsize, input logic [31:0] wdata,
                             input logic [3:0] raddr, output logic [31:0] rdata);
        applyStimulus(1'b1, 2'b10, 1'b1, waddr, wsize, 32'h0, 1'b1);
        tick();
        applyStimulus(1'b1, 2'b10, 1'b0, raddr, 3'd2, wdata, 1'b1);
        #1 checkOutput("b2b write dphase");
        tick();
        applyStimulus(1'b0, 2'b00, 1'b0, 4'h0, 3'd2, 32'h0, 1'b1);
        #1 rdata = HRDATA;
        checkOutput("b2b read dphase");
        tick();
    endtask

    typedef struct {
        string       name;
        logic [3:0]  addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [31:0] expRead;
    } vec_t;

    initial begin
        vec_t        vecs[15];
        logic [31:0] r;
        logic [31:0] wd;

        HRESETn = 1'b0;
        applyStimulus(1'b0, 2'b00, 1'b0, 4'h0, 3'd0, 32'h0, 1'b1);
        modelReset();
        repeat (3) @(posedge HCLK);
        #1 HRESETn = 1'b1;
        #1 checkOutput("reset");
        checkVal("reset LED", {24'h0, LED}, {24'h0, RESET_LED});
        busRead(4'h0, r); checkVal("reset DATA", r, {24'h0, RESET_LED});
        busRead(4'h4, r); checkVal("reset BLINK", r, 32'h0);
        busRead(4'h8, r); checkVal("reset PERIOD", r, 32'h0);
        busRead(4'hC, r); checkVal("reset STATUS", r, 32'h0);

        // Word write to DATA: register updates at the commit edge, LED one cycle later.
        applyStimulus(1'b1, 2'b10, 1'b1, 4'h0, 3'd2, 32'h0, 1'b1);
        tick();
        applyStimulus(1'b0, 2'b00, 1'b0, 4'h0, 3'd2, 32'h0000_00A5, 1'b1);
        #1 checkVal("LED before commit", {24'h0, LED}, {24'h0, RESET_LED});
        tick();
        checkVal("LED at commit edge", {24'h0, LED}, {24'h0, RESET_LED});
        checkOutput("commit edge");
        applyStimulus(1'b0, 2'b00, 1'b0, 4'h0, 3'd2, 32'h0, 1'b1);
        tick();
        checkVal("LED one cycle later", {24'h0, LED}, 32'hA5);
        busRead(4'h0, r); checkVal("DATA readback", r, 32'h0000_00A5);

        vecs[0]  = '{"word DATA",         4'h0, 3'd2, 32'h0000_00A5, 32'h0000_00A5};
        vecs[1]  = '{"byte lane1 DATA",   4'h1, 3'd0, 32'h0000_FF00, 32'h0000_00A5};
        vecs[2]  = '{"byte lane0 DATA",   4'h0, 3'd0, 32'h0000_003C, 32'h0000_003C};
        vecs[3]  = '{"half upper DATA",   4'h2, 3'd1, 32'hFFFF_0000, 32'h0000_003C};
        vecs[4]  = '{"word BLINK",        4'h4, 3'd2, 32'hFFFF_FF5A, 32'h0000_005A};
        vecs[5]  = '{"half low PERIOD",   4'h8, 3'd1, 32'h1234_5678, 32'h0000_5678};
        vecs[6]  = '{"clear PERIOD",      4'h8, 3'd2, 32'h0000_0000, 32'h0000_0000};
        vecs[7]  = '{"byte lane1 PERIOD", 4'h9, 3'd0, 32'h0000_3C00, 32'h0000_3C00};
        vecs[8]  = '{"size3 PERIOD",      4'h8, 3'd3, 32'hAABB_CCDD, 32'h00BB_CCDD};
        vecs[9]  = '{"byte lane2 PERIOD", 4'hA, 3'd0, 32'h0077_0000, 32'h0077_CCDD};
        vecs[10] = '{"zero PERIOD",       4'h8, 3'd2, 32'h0000_0000, 32'h0000_0000};
        vecs[11] = '{"byte lane3 BLINK",  4'h7, 3'd0, 32'h9900_0000, 32'h0000_005A};
        vecs[12] = '{"half low BLINK",    4'h4, 3'd1, 32'h0000_00C3, 32'h0000_00C3};
        vecs[13] = '{"write STATUS",      4'hC, 3'd2, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[14] = '{"half upper BLINK",  4'h6, 3'd1, 32'hFFFF_0000, 32'h0000_00C3};
        for (int i = 0; i < 15; i++) begin
            writeRead(vecs[i].addr, vecs[i].size, vecs[i].wdata, {vecs[i].addr[3:2], 2'b00}, r);
            checkVal(vecs[i].name, r, vecs[i].expRead);
        end

        // Byte write into PERIOD restarts the blink state; STATUS reads back zero.
        writeRead(4'h9, 3'd0, 32'h0000_3C00, 4'hC, r);
        checkVal("STATUS after PERIOD write", r, 32'h0);
        busRead(4'h8, r); checkVal("PERIOD lane1", r, 32'h0000_3C00);
        busRead(4'hC, r);

        // IDLE and unselected writes leave DATA alone and return zero read data.
        applyStimulus(1'b1, 2'b00, 1'b1, 4'h0, 3'd2, 32'h0, 1'b1);
        tick();
        applyStimulus(1'b0, 2'b10, 1'b1, 4'h0, 3'd2, 32'h11, 1'b1);
        #1 checkVal("IDLE dphase HRDATA", HRDATA, 32'h0);
        checkOutput("IDLE dphase");
        tick();
        applyStimulus(1'b0, 2'b00, 1'b0, 4'h0, 3'd2, 32'h22, 1'b1);
        #1 checkVal("unselected dphase HRDATA", HRDATA, 32'h0);
        tick();
        busRead(4'h0, r); checkVal("DATA untouched", r, 32'h0000_003C);

        // Blink at PERIOD=4: LED alternates FF/F0 in runs of four cycles.
        busWrite(4'h0, 3'd2, 32'hFF);
        busWrite(4'h4, 3'd2, 32'h0F);
        busWrite(4'h8, 3'd2, 32'h4);
        for (int i = 1; i <= 24; i++) begin
            applyStimulus(1'b0, 2'b00, 1'b0, 4'h0, 3'd2, 32'h0, 1'b1);
            tick();
            checkVal($sformatf("blink cycle %0d", i), {24'h0, LED},
                     (((i - 1) / 4) % 2 == 1) ? 32'hF0 : 32'hFF);
            checkOutput("blink");
        end
        busWrite(4'h8, 3'd2, 32'h0);
        tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            checkVal("steady after PERIOD=0", {24'h0, LED}, 32'hFF);
        end

        // Reset pulse during a write data phase discards the write.
        applyStimulus(1'b1, 2'b10, 1'b1, 4'h0, 3'd2, 32'h0, 1'b1);
        tick();
        applyStimulus(1'b0, 2'b00, 1'b0, 4'h0, 3'd2, 32'h77, 1'b1);
        #2 HRESETn = 1'b0;
        #1 checkVal("LED async reset", {24'h0, LED}, {24'h0, RESET_LED});
        checkVal("HRDATA in reset", HRDATA, 32'h0);
        modelReset();
        #1 HRESETn = 1'b1;
        tick();
        checkOutput("after reset release");
        busRead(4'h0, r); checkVal("DATA after aborted write", r, {24'h0, RESET_LED});
        writeRead(4'h0, 3'd2, 32'h42, 4'h0, r);
        checkVal("first write after reset", r, 32'h42);

        // Random traffic with occasional stalls and small periods so blinking is visible.
        for (int i = 0; i < 500; i++) begin
            wd = $urandom;
            if (mVal && mWr && mAddr[3:2] == 2'd2 && $urandom_range(0, 3) != 0)
                wd = $urandom_range(0, 6);
            applyStimulus($urandom_range(0, 9) < 8, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          4'($urandom_range(0, 15)), 3'($urandom_range(0, 4)), wd,
                          $urandom_range(0, 9) != 0);
            #1 checkOutput($sformatf("random %0d", i));
            tick();
        end
        applyStimulus(1'b0, 2'b00, 1'b0, 4'h0, 3'd2, 32'h0, 1'b1);
        repeat (3) tick();
        checkOutput("final");

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
